// File: rtl/macro_sel_pkg.sv
// Shared types and constants for the macro bus/pad selection controller.
// Register offsets are byte offsets within the 256-byte control window.
package macro_sel_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StGuard  = 2'd2
    } state_e;

    localparam logic [7:0]  RegSelOff      = 8'h00;
    localparam logic [7:0]  RegStatusOff   = 8'h04;

    localparam int unsigned SelEnBit       = 31;
    localparam int unsigned StatStateLsb   = 4;
    localparam int unsigned StatTimeoutBit = 8;
    localparam int unsigned StatBadSelBit  = 9;

    localparam logic [31:0] TimeoutRdata   = 32'hDEAD_DEAD;
    localparam logic [31:0] IdleRdata      = 32'h0000_0000;

endpackage

// File: rtl/macro_sel_wdog.sv
// Watchdog for forwarded accesses: counts cycles an access is outstanding and
// flags a timeout when the count reaches Timeout; any ack clears the count.
module macro_sel_wdog #(
    parameter int unsigned Timeout = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pend_i,
    input  logic ack_i,
    output logic timeout_o
);

    localparam int unsigned CntW = $clog2(Timeout + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign cnt_d     = (ack_i || !pend_i) ? '0 : cnt_q + 1'b1;
    assign timeout_o = pend_i && (cnt_q == CntW'(Timeout));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/macro_sel_ctrl.sv
// Shares the Wishbone slave port and IO pads among NUM_MACROS test macros, with a
// pad-released guard interval on every owner switch and a forwarded-access watchdog.
module macro_sel_ctrl #(
    parameter int unsigned NUM_MACROS   = 3,
    parameter int unsigned IO_PADS      = 38,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] CTRL_BASE    = 32'h3000_0000
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [31:0]                   wbs_adr_i,
    input  logic [31:0]                   wbs_dat_i,
    output logic                          wbs_ack_o,
    output logic [31:0]                   wbs_dat_o,
    output logic [NUM_MACROS-1:0]         m_cyc_o,
    output logic [NUM_MACROS-1:0]         m_stb_o,
    output logic                          m_we_o,
    output logic [3:0]                    m_sel_o,
    output logic [31:0]                   m_adr_o,
    output logic [31:0]                   m_dat_o,
    input  logic [NUM_MACROS-1:0]         m_ack_i,
    input  logic [32*NUM_MACROS-1:0]      m_dat_i,
    input  logic [IO_PADS*NUM_MACROS-1:0] m_io_out_i,
    input  logic [IO_PADS*NUM_MACROS-1:0] m_io_oeb_i,
    output logic [IO_PADS-1:0]            io_out_o,
    output logic [IO_PADS-1:0]            io_oeb_o,
    output logic [NUM_MACROS-1:0]         io_active_o
);

    import macro_sel_pkg::*;

    localparam logic [3:0] GuardLoad = 4'(GUARD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  sel_idx_q, sel_idx_d, owner_q, owner_d;
    logic        sel_en_q, sel_en_d, sel_wr_q, sel_wr_d;
    logic        to_q, to_d, bad_q, bad_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  guard_q, guard_d;

    logic        req, hit, fwd, ctrl_req, idle_req, timeout, fwd_ack;
    logic [7:0]  offset;
    logic [1:0]  wr_idx;
    logic        wr_en, sel_bad;
    logic [31:0] status, fwd_dat;

    assign req      = wbs_cyc_i & wbs_stb_i;
    assign hit      = wbs_adr_i[31:8] == CTRL_BASE[31:8];
    assign fwd      = req & ~hit;
    assign offset   = {wbs_adr_i[7:2], 2'b00};
    // Gating on ack_q keeps a strobe held through the ack cycle from being re-accepted.
    assign ctrl_req = req & hit & ~ack_q;
    assign idle_req = fwd & ~ack_q & (state_q == StIdle);

    assign m_we_o  = wbs_we_i;
    assign m_sel_o = wbs_sel_i;
    assign m_adr_o = wbs_adr_i;
    assign m_dat_o = wbs_dat_i;

    macro_sel_wdog #(
        .Timeout (TIMEOUT)
    ) u_wdog (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rst_ni),
        .pend_i    (fwd && (state_q != StIdle)),
        .ack_i     (wbs_ack_o),
        .timeout_o (timeout)
    );

    // Control register file; rejected SEL writes leave SEL untouched but are still acked.
    always_comb begin
        wr_idx    = wbs_sel_i[0] ? wbs_dat_i[1:0] : sel_idx_q;
        wr_en     = wbs_sel_i[3] ? wbs_dat_i[SelEnBit] : sel_en_q;
        sel_bad   = 32'(wr_idx) >= NUM_MACROS;
        status    = '0;
        status[1:0]                 = owner_q;
        status[StatStateLsb +: 2]   = state_q;
        status[StatTimeoutBit]      = to_q;
        status[StatBadSelBit]       = bad_q;

        sel_idx_d = sel_idx_q;
        sel_en_d  = sel_en_q;
        sel_wr_d  = 1'b0;
        to_d      = to_q;
        bad_d     = bad_q;
        ack_d     = ctrl_req | idle_req;
        rdata_d   = IdleRdata;

        if (ctrl_req) begin
            if (offset == RegSelOff) begin
                rdata_d = {sel_en_q, 29'b0, sel_idx_q};
                if (wbs_we_i) begin
                    if (sel_bad) begin
                        bad_d = 1'b1;
                    end else begin
                        sel_idx_d = wr_idx;
                        sel_en_d  = wr_en;
                        sel_wr_d  = 1'b1;
                    end
                end
            end else if (offset == RegStatusOff) begin
                rdata_d = status;
                if (wbs_we_i && wbs_sel_i[1]) begin
                    if (wbs_dat_i[StatTimeoutBit]) to_d  = 1'b0;
                    if (wbs_dat_i[StatBadSelBit])  bad_d = 1'b0;
                end
            end
        end
        if (timeout) to_d = 1'b1;
    end

    // The FSM reacts in the SEL ack cycle, so the guard starts the cycle after the ack.
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        owner_d = owner_q;
        unique case (state_q)
            StIdle: begin
                if (sel_wr_q && sel_en_q) begin
                    state_d = StGuard;
                    guard_d = GuardLoad;
                end
            end
            StActive: begin
                if (sel_wr_q && (!sel_en_q || (sel_idx_q != owner_q))) begin
                    state_d = StGuard;
                    guard_d = GuardLoad;
                end
            end
            StGuard: begin
                if (sel_wr_q) begin
                    guard_d = GuardLoad;
                end else if (guard_q == 4'd0) begin
                    state_d = sel_en_q ? StActive : StIdle;
                    owner_d = sel_en_q ? sel_idx_q : owner_q;
                end else begin
                    guard_d = guard_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_cyc_o     = '0;
        m_stb_o     = '0;
        io_active_o = '0;
        io_out_o    = '0;
        io_oeb_o    = '1;
        fwd_ack     = 1'b0;
        fwd_dat     = IdleRdata;
        if (state_q == StActive) begin
            for (int unsigned m = 0; m < NUM_MACROS; m++) begin
                if (owner_q == m[1:0]) begin
                    io_active_o[m] = 1'b1;
                    m_cyc_o[m]     = fwd;
                    m_stb_o[m]     = fwd & ~timeout;
                    fwd_ack        = fwd & m_ack_i[m];
                    fwd_dat        = m_dat_i[32*m +: 32];
                    io_out_o       = m_io_out_i[IO_PADS*m +: IO_PADS];
                    io_oeb_o       = m_io_oeb_i[IO_PADS*m +: IO_PADS];
                end
            end
        end
        wbs_ack_o = ack_q | timeout | fwd_ack;
        wbs_dat_o = timeout ? TimeoutRdata : (ack_q ? rdata_q : fwd_dat);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= StIdle;
            sel_idx_q <= '0;
            sel_en_q  <= 1'b0;
            sel_wr_q  <= 1'b0;
            owner_q   <= '0;
            to_q      <= 1'b0;
            bad_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            guard_q   <= '0;
        end else begin
            state_q   <= state_d;
            sel_idx_q <= sel_idx_d;
            sel_en_q  <= sel_en_d;
            sel_wr_q  <= sel_wr_d;
            owner_q   <= owner_d;
            to_q      <= to_d;
            bad_q     <= bad_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            guard_q   <= guard_d;
        end
    end

endmodule

// File: tb/tb_macro_sel_ctrl.sv
// Directed self-checking bench for macro_sel_ctrl with three behavioural macros
// that ack immediately unless their ack is disabled.
module tb_macro_sel_ctrl;

    localparam int unsigned NM = 3;
    localparam int unsigned NP = 38;
    localparam logic [31:0] CTRL = 32'h3000_0000;
    localparam logic [7:0]  OFF_SEL = 8'h00;
    localparam logic [7:0]  OFF_STAT = 8'h04;
    localparam logic [NP-1:0] OUT_PAT [NM] = '{38'h3F_0000_00A1, 38'h15_5555_5555,
                                                38'h2A_AAAA_AAAA};
    localparam logic [NP-1:0] OEB_PAT [NM] = '{38'h00_0000_FFFF, 38'h0F_0F0F_0F0F,
                                                38'h30_F0F0_F0F0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, stb, cyc, we, ack;
    logic [3:0]        sel, m_sel;
    logic [31:0]       adr, dat, dat_o, m_adr, m_dat_bc;
    logic              m_we;
    logic [NM-1:0]     m_cyc, m_stb, m_ack, io_active, ack_en;
    logic [32*NM-1:0]  m_dat;
    logic [NP*NM-1:0]  m_io_out, m_io_oeb;
    logic [NP-1:0]     io_out, io_oeb;

    int n_cmp = 0;
    int n_err = 0;

    assign m_ack = m_stb & ack_en;

    always_comb begin
        m_dat    = '0;
        m_io_out = '0;
        m_io_oeb = '0;
        for (int m = 0; m < NM; m++) begin
            m_dat[32*m +: 32]    = 32'hA000_0000 + 32'(m);
            m_io_out[NP*m +: NP] = OUT_PAT[m];
            m_io_oeb[NP*m +: NP] = OEB_PAT[m];
        end
    end

    macro_sel_ctrl #(
        .NUM_MACROS   (NM),
        .IO_PADS      (NP),
        .GUARD_CYCLES (4),
        .TIMEOUT      (255),
        .CTRL_BASE    (CTRL)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .m_cyc_o     (m_cyc),
        .m_stb_o     (m_stb),
        .m_we_o      (m_we),
        .m_sel_o     (m_sel),
        .m_adr_o     (m_adr),
        .m_dat_o     (m_dat_bc),
        .m_ack_i     (m_ack),
        .m_dat_i     (m_dat),
        .m_io_out_i  (m_io_out),
        .m_io_oeb_i  (m_io_oeb),
        .io_out_o    (io_out),
        .io_oeb_o    (io_oeb),
        .io_active_o (io_active)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts at posedge+1, returns at posedge+1 of the cycle after the ack.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, output logic [31:0] rd, output int lat,
                           output logic [NM-1:0] snap);
        logic done;
        done = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = be;
        lat = 0; rd = '0; snap = '0;
        while (!done && lat < 400) begin
            #1;
            if (ack) begin
                rd   = dat_o;
                snap = m_stb;
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (!done) lat++;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check_eq("xfer_ack_seen", 64'(done), 64'd1);
    endtask

    task automatic ctrl_wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] be,
                           input string tag);
        logic [31:0] rd;
        int lat;
        logic [NM-1:0] snap;
        wb_xfer(1'b1, CTRL | 32'(off), d, be, rd, lat, snap);
        check_eq({tag, "_lat"}, 64'(lat), 64'd1);
    endtask

    task automatic ctrl_rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        int lat;
        logic [NM-1:0] snap;
        wb_xfer(1'b0, CTRL | 32'(off), 32'h0, 4'hF, rd, lat, snap);
        check_eq({tag, "_lat"}, 64'(lat), 64'd1);
        check_eq(tag, rd, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int lat;
        logic [NM-1:0] snap;

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = '0; adr = '0; dat = '0; ack_en = '1;
        step(3);
        check_eq("rst_oeb", io_oeb, {NP{1'b1}});
        check_eq("rst_out", io_out, 0);
        check_eq("rst_active", io_active, 0);
        check_eq("rst_ack", ack, 0);
        check_eq("rst_stb", m_stb, 0);
        rst_n = 1'b1;
        step(1);

        ctrl_rd(OFF_STAT, 32'h0, "status_rst");
        ctrl_rd(OFF_SEL, 32'h0, "sel_rst");
        wb_xfer(1'b0, 32'h0000_1000, 32'h0, 4'hF, rd, lat, snap);
        check_eq("idle_fwd_lat", lat, 1);
        check_eq("idle_fwd_dat", rd, 32'h0);

        // Select macro 1: four released cycles, then ownership.
        ctrl_wr(OFF_SEL, 32'h8000_0001, 4'hF, "sel1");
        check_eq("g1_active", io_active, 0);
        check_eq("g1_oeb", io_oeb, {NP{1'b1}});
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_eq("g1_hold", io_active, 0);
        end
        step(1);
        check_eq("own1_active", io_active, 3'b010);
        check_eq("own1_out", io_out, OUT_PAT[1]);
        check_eq("own1_oeb", io_oeb, OEB_PAT[1]);
        ctrl_rd(OFF_STAT, 32'h0000_0011, "status_own1");
        wb_xfer(1'b0, 32'h0000_2000, 32'h0, 4'hF, rd, lat, snap);
        check_eq("own1_fwd_lat", lat, 0);
        check_eq("own1_fwd_dat", rd, 32'hA000_0001);
        check_eq("own1_fwd_stb", snap, 3'b010);

        // Switch to macro 2 with an access issued during the guard.
        ctrl_wr(OFF_SEL, 32'h8000_0002, 4'hF, "sel2");
        check_eq("g2_active", io_active, 0);
        check_eq("g2_oeb", io_oeb, {NP{1'b1}});
        wb_xfer(1'b0, 32'h0000_3000, 32'h0, 4'hF, rd, lat, snap);
        check_eq("g2_fwd_lat", lat, 4);
        check_eq("g2_fwd_dat", rd, 32'hA000_0002);
        check_eq("g2_fwd_stb", snap, 3'b100);
        check_eq("own2_active", io_active, 3'b100);
        check_eq("own2_out", io_out, OUT_PAT[2]);

        // Same-index write: no guard. Bad index: rejected, sticky set, then W1C.
        ctrl_wr(OFF_SEL, 32'h8000_0002, 4'hF, "sel_same");
        check_eq("same_noguard", io_active, 3'b100);
        ctrl_wr(OFF_SEL, 32'h8000_0003, 4'hF, "sel_bad");
        check_eq("bad_noguard", io_active, 3'b100);
        step(6);
        check_eq("bad_owner_kept", io_active, 3'b100);
        ctrl_rd(OFF_STAT, 32'h0000_0212, "status_bad");
        ctrl_rd(OFF_SEL, 32'h8000_0002, "sel_after_bad");
        ctrl_wr(OFF_STAT, 32'h0000_0200, 4'hF, "clr_bad");
        ctrl_rd(OFF_STAT, 32'h0000_0012, "status_bad_clr");

        // Owner never acks: watchdog completes the access.
        ack_en = '0;
        wb_xfer(1'b0, 32'h0000_4000, 32'h0, 4'hF, rd, lat, snap);
        check_eq("wd_lat", lat, 255);
        check_eq("wd_dat", rd, 32'hDEAD_DEAD);
        check_eq("wd_stb", snap, 3'b000);
        ack_en = '1;
        ctrl_rd(OFF_STAT, 32'h0000_0112, "status_to");
        ctrl_wr(OFF_STAT, 32'h0000_0100, 4'hF, "clr_to");
        ctrl_rd(OFF_STAT, 32'h0000_0012, "status_to_clr");

        // Reset asserted mid-guard, held past the guard length.
        ctrl_wr(OFF_SEL, 32'h8000_0000, 4'hF, "sel0");
        step(1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_oeb", io_oeb, {NP{1'b1}});
        check_eq("midrst_ack", ack, 0);
        step(8);
        check_eq("midrst_active", io_active, 0);
        check_eq("midrst_out", io_out, 0);
        rst_n = 1'b1;
        step(1);
        ctrl_rd(OFF_STAT, 32'h0, "status_after_rst");
        ctrl_rd(OFF_SEL, 32'h0, "sel_after_rst");

        // Byte lanes: index alone leaves enable clear; enable alone keeps index.
        ctrl_wr(OFF_SEL, 32'h8000_0001, 4'b0001, "lane0");
        step(6);
        check_eq("lane0_idle", io_active, 0);
        ctrl_rd(OFF_SEL, 32'h0000_0001, "lane0_sel");
        ctrl_wr(OFF_SEL, 32'h8000_0000, 4'b1000, "lane3");
        step(6);
        check_eq("lane3_active", io_active, 3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/macro_sel_ctrl.md
# macro_sel_ctrl

Arbiter and sequencer that shares the user-area Wishbone slave port and the 38 IO pads among NUM_MACROS test macros (golden, decap, tap, …). It sits between the wrapper's Caravel-facing ports and the macros, so exactly one macro owns the bus and pads at any time. A register-programmed selection sets the owner, and a guard interval with pads released separates owners on every switch. A watchdog completes forwarded accesses that the owner never acknowledges.

## Interface
- NUM_MACROS, 3, number of macros sharing bus/pads (2..4)
- IO_PADS, 38, pad count
- GUARD_CYCLES, 4, dead cycles on owner switch (1..15)
- TIMEOUT, 255, max cycles a forwarded access may wait for ack (> GUARD_CYCLES+2)
- CTRL_BASE, 32'h3000_0000, control window base; hit when wbs_adr_i[31:8]==CTRL_BASE[31:8]

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone from Caravel
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i, wbs_dat_i  in  32
- wbs_ack_o  out  1; wbs_dat_o  out  32
- m_cyc_o, m_stb_o  out  NUM_MACROS  per-macro strobes; m_we/sel/adr/dat broadcast unchanged from wbs_*
- m_ack_i  in  NUM_MACROS; m_dat_i  in  32*NUM_MACROS
- m_io_out_i, m_io_oeb_i  in  IO_PADS*NUM_MACROS
- io_out_o, io_oeb_o  out  IO_PADS
- io_active_o  out  NUM_MACROS  one-hot owner enable

## Operation
- Registers, word-aligned in control window:
  - 0x00 SEL: [1:0] index (byte 0), [31] enable (byte 3); honours wbs_sel_i
  - 0x04 STATUS (RO except W1C): [1:0] current owner, [5:4] state, [8] timeout sticky (W1C), [9] bad_sel sticky (W1C)
  - other offsets: read 0, writes ignored
- FSM states IDLE=0, ACTIVE=1, GUARD=2:
  - IDLE → GUARD: accepted SEL write with enable=1
  - ACTIVE → GUARD: accepted SEL write changing index or clearing enable
  - GUARD → ACTIVE (enable=1) or IDLE (enable=0) after GUARD_CYCLES cycles
- SEL write with same index and enable=1 while ACTIVE: ack only, no guard.
- SEL write with index ≥ NUM_MACROS: whole write rejected (SEL unchanged), bad_sel set, still acked.
- SEL write during GUARD: registers updated; guard counter restarts.
- Outputs per state:
  - ACTIVE: io_active_o = 1<<owner; io_out_o/io_oeb_o muxed from owner.
  - IDLE and GUARD: io_active_o=0, io_out_o=0, io_oeb_o=all 1.
- Forwarded access (no window hit):
  - ACTIVE: m_cyc_o/m_stb_o[owner] = wbs_cyc_i&wbs_stb_i; wbs_ack_o/wbs_dat_o pass through from owner combinationally.
  - GUARD: stalled, no strobe.
  - IDLE: acked next cycle with dat 32'h0.
- Watchdog:
  - counts cycles while a forwarded access is outstanding (stb&cyc, no ack).
  - at count==TIMEOUT: controller drives ack one cycle with dat 32'hDEAD_DEAD, sets timeout sticky, forces m_stb_o low that cycle.
  - counter clears on any ack.

## Timing
- Control access: stb&cyc sampled at edge t → wbs_ack_o high cycle t+1 for exactly one cycle, registered; read data valid with ack; register update on the same edge. No re-ack while stb held across the ack cycle.
- GUARD begins the cycle after the SEL ack; new owner is visible on io_active_o exactly GUARD_CYCLES+1 cycles after that ack.
- Forwarded path: zero added latency.
- Reset values: all outputs 0 except io_oeb_o=all 1; SEL=0, stickies 0, state IDLE, counters 0. Reset asserted mid-access drops acks/strobes immediately; an access in flight is lost.

## Structure
- Package macro_sel_pkg: state enum, register offsets, field bit positions, DEAD_DEAD/idle read constants.
- Sub-module macro_sel_wdog: outstanding-access counter, TIMEOUT compare, clear-on-ack; all else in macro_sel_ctrl.

## Test plan
- Reset, no writes → io_oeb_o=all 1, io_active_o=0, STATUS reads 0x0; forwarded read acked next cycle with 0.
- Write SEL=0x8000_0001 → ack 1 cycle later, io_active_o=3'b000 for 4 cycles, then 3'b010; io_out_o equals macro 1 pads.
- While owner 1 ACTIVE, write SEL=0x8000_0002 → pads released 4 cycles, then 3'b100; a forwarded access issued during guard stalls and completes from macro 2.
- Write SEL=0x8000_0003 (NUM_MACROS=3) → acked, owner unchanged, STATUS[9]=1; write 0x200 to 0x04 clears it.
- Owner never acks → ack at cycle 255 with 0xDEAD_DEAD, STATUS[8]=1, m_stb_o low that cycle.
- Assert wb_rst_ni low mid-guard → all outputs to reset values same cycle, state IDLE after release.
